// File: rtl/clk_enable_gen_pkg.sv
// Shared types and constants for the clock-enable generator.
package clk_gen_pkg;

    // Operating modes, encoded exactly as driven on mode_i.
    typedef enum logic [1:0] {
        HALT  = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10,
        BURST = 2'b11
    } mode_t;

    // Width of the free-running tick counter.
    localparam int TICK_CNT_W = 16;

endpackage

// File: rtl/clk_enable_gen_if.sv
// Control and status bundle between the bring-up controls and the enable generator.
interface clk_enable_gen_if
    import clk_gen_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 8
) ();

    logic [1:0]            mode_i;
    logic [CNT_W-1:0]      div_i;
    logic [BURST_W-1:0]    burst_len_i;
    logic                  tick_o;
    logic                  busy_o;
    logic [TICK_CNT_W-1:0] tick_count_o;
    logic                  led_o;

    // Side that sets mode, divisor and burst length and watches the tick.
    modport master (
        output mode_i, div_i, burst_len_i,
        input  tick_o, busy_o, tick_count_o, led_o
    );

    // The enable generator itself.
    modport slave (
        input  mode_i, div_i, burst_len_i,
        output tick_o, busy_o, tick_count_o, led_o
    );

endinterface

// File: rtl/clk_enable_gen_step_debouncer.sv
// Step button conditioning: 2-flop synchroniser, stability filter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int STAB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic              level_prev_q;
    logic              press_q;
    logic [STAB_W-1:0] stab_q, stab_d;

    // Stability filter: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        stab_d  = stab_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            stab_d  = '0;
        end else begin
            stab_d = stab_q + STAB_W'(1);
        end
    end

    // Synchroniser, filter state and edge-detect registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge like any other input; state updates use <= only.
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stab_q       <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stab_q       <= stab_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Single-clock enable generator for CPU bring-up: HALT / RUN / STEP / BURST
// modes, runtime divisor, debounced step button, tick counter and heartbeat LED.
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int DEFAULT_DIV     = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BURST_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_btn_i,
    clk_enable_gen_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 1 || DEFAULT_DIV < 0) begin : g_param_check
        $error("clk_enable_gen: DEBOUNCE_CYCLES must be >= 1 and DEFAULT_DIV >= 0");
    end

    mode_t                 state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      div_eff;
    logic [BURST_W-1:0]    rem_q, rem_d;
    logic [BURST_W-1:0]    len_eff;
    logic                  busy_q, busy_d;
    logic                  tick_q, tick_d;
    logic                  led_q, led_d;
    logic [TICK_CNT_W-1:0] count_q, count_d;
    logic                  press;
    logic                  period_done;

    step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debouncer (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (step_btn_i),
        .press_o(press)
    );

    assign div_eff = (bus.div_i == '0) ? CNT_W'(1) : bus.div_i;
    assign len_eff = (bus.burst_len_i == '0) ? BURST_W'(1) : bus.burst_len_i;
    // >= rather than == so a divisor lowered mid-count ends the period at once.
    assign period_done = (cnt_q >= div_eff - CNT_W'(1));

    // Next-state, divide counter, burst bookkeeping and tick decision.
    always_comb begin
        state_d = mode_t'(bus.mode_i);
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        tick_d  = 1'b0;
        if (state_d != state_q) begin
            // Any mode change restarts the period and aborts a burst.
            cnt_d  = '0;
            rem_d  = '0;
            busy_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (period_done) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STEP: begin
                    tick_d = press;
                end
                BURST: begin
                    if (!busy_q) begin
                        if (press) begin
                            rem_d  = len_eff;
                            busy_d = 1'b1;
                            cnt_d  = '0;
                        end
                    end else if (period_done) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        rem_d  = rem_q - BURST_W'(1);
                        if (rem_q == BURST_W'(1)) begin
                            busy_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // HALT: hold everything, no ticks.
                end
            endcase
        end
        count_d = tick_d ? count_q + TICK_CNT_W'(1) : count_q;
        led_d   = led_q ^ tick_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HALT;
            cnt_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            led_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            count_q <= count_d;
        end
    end

    assign bus.tick_o       = tick_q;
    assign bus.busy_o       = busy_q;
    assign bus.tick_count_o = count_q;
    assign bus.led_o        = led_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen. Expected ticks are derived from the
// mode timing rules (edge arithmetic from the mode-change or press edge);
// tick count and LED follow from the running total of expected ticks.
module tb_clk_enable_gen;
    import clk_gen_pkg::*;

    localparam int CNT_W   = 32;
    localparam int BURST_W = 8;
    localparam int DEB     = 4;
    // Edge index (first sampled-high edge = 1) at which the top sees a press.
    localparam int PRESS_EDGE = 1 + (2 + DEB + 1);

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic step_btn = 1'b0;

    int checks      = 0;
    int errors      = 0;
    int model_ticks = 0;

    clk_enable_gen_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    clk_enable_gen #(
        .CNT_W          (CNT_W),
        .DEFAULT_DIV    (1),
        .DEBOUNCE_CYCLES(DEB),
        .BURST_W        (BURST_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step_btn_i(step_btn),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.mode_i      = RUN;
        bus.div_i       = 1;
        bus.burst_len_i = 1;
        step_btn        = 1'b0;
        repeat (3) next_edge();
        checks += 4;
        if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL reset tick_o: got %b want 0", bus.tick_o); end
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset busy_o: got %b want 0", bus.busy_o); end
        if (bus.tick_count_o !== 16'h0000) begin errors++; $display("FAIL reset tick_count_o: got %h want 0000", bus.tick_count_o); end
        if (bus.led_o !== 1'b0) begin errors++; $display("FAIL reset led_o: got %b want 0", bus.led_o); end
        reset       = 1'b0;
        bus.mode_i  = HALT;
        model_ticks = 0;
        repeat (2) next_edge();
        checks += 1;
        if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL halt_after_reset tick_o: got %b want 0", bus.tick_o); end
    endtask

    task automatic test_run(input int div, input int periods);
        int  n;
        bit  exp_tick;
        n = (div == 0) ? 1 : div;
        bus.mode_i = HALT;
        repeat (2) begin
            next_edge();
            checks += 2;
            if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL run_halt div=%0d tick_o: got %b want 0", div, bus.tick_o); end
            if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL run_halt div=%0d busy_o: got %b want 0", div, bus.busy_o); end
        end
        bus.div_i  = div;
        bus.mode_i = RUN;
        for (int k = 0; k <= n * periods; k++) begin
            next_edge();
            exp_tick = (k >= 1) && (k % n == 0);
            if (exp_tick) model_ticks++;
            checks += 3;
            if (bus.tick_o !== exp_tick) begin errors++; $display("FAIL run div=%0d edge=%0d tick_o: got %b want %b", div, k, bus.tick_o, exp_tick); end
            if (bus.tick_count_o !== 16'(model_ticks)) begin errors++; $display("FAIL run div=%0d edge=%0d tick_count_o: got %0d want %0d", div, k, bus.tick_count_o, 16'(model_ticks)); end
            if (bus.led_o !== model_ticks[0]) begin errors++; $display("FAIL run div=%0d edge=%0d led_o: got %b want %b", div, k, bus.led_o, model_ticks[0]); end
        end
    endtask

    task automatic test_div_change();
        bit exp_tick;
        bus.mode_i = HALT;
        repeat (2) next_edge();
        bus.div_i  = 10;
        bus.mode_i = RUN;
        for (int k = 0; k <= 12; k++) begin
            // Counter has reached 5 after edge 5; the new divisor is seen at edge 6.
            if (k == 6) bus.div_i = 2;
            next_edge();
            exp_tick = (k >= 6) && ((k - 6) % 2 == 0);
            if (exp_tick) model_ticks++;
            checks += 2;
            if (bus.tick_o !== exp_tick) begin errors++; $display("FAIL div_change edge=%0d tick_o: got %b want %b", k, bus.tick_o, exp_tick); end
            if (bus.tick_count_o !== 16'(model_ticks)) begin errors++; $display("FAIL div_change edge=%0d tick_count_o: got %0d want %0d", k, bus.tick_count_o, 16'(model_ticks)); end
        end
    endtask

    task automatic test_step();
        int len;
        int hold;
        int gap;
        bit exp_tick;
        bus.mode_i = STEP;
        bus.div_i  = $urandom_range(2, 9);
        repeat (3) next_edge();
        // Glitches shorter than the debounce window never produce a tick.
        for (int g = 0; g < 3; g++) begin
            len = $urandom_range(1, DEB - 1);
            for (int i = 1; i <= len + 12; i++) begin
                step_btn = (i <= len);
                next_edge();
                checks += 1;
                if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL step_glitch len=%0d edge=%0d tick_o: got %b want 0", len, i, bus.tick_o); end
            end
        end
        // Clean presses: exactly one tick each, at a fixed latency.
        for (int p = 0; p < 3; p++) begin
            hold = (p == 0) ? 20 : $urandom_range(DEB + 2, 20);
            gap  = $urandom_range(10, 14);
            for (int i = 1; i <= hold + gap; i++) begin
                step_btn = (i <= hold);
                next_edge();
                exp_tick = (i == PRESS_EDGE);
                if (exp_tick) model_ticks++;
                checks += 3;
                if (bus.tick_o !== exp_tick) begin errors++; $display("FAIL step press=%0d edge=%0d tick_o: got %b want %b", p, i, bus.tick_o, exp_tick); end
                if (bus.tick_count_o !== 16'(model_ticks)) begin errors++; $display("FAIL step press=%0d edge=%0d tick_count_o: got %0d want %0d", p, i, bus.tick_count_o, 16'(model_ticks)); end
                if (bus.led_o !== model_ticks[0]) begin errors++; $display("FAIL step press=%0d edge=%0d led_o: got %b want %b", p, i, bus.led_o, model_ticks[0]); end
            end
        end
    endtask

    task automatic test_burst(input int div, input int len, input bit repress);
        int n;
        int l;
        int last;
        int win;
        int d;
        bit exp_tick;
        bit exp_busy;
        n = (div == 0) ? 1 : div;
        l = (len == 0) ? 1 : len;
        bus.mode_i      = BURST;
        bus.div_i       = div;
        bus.burst_len_i = len;
        repeat (3) next_edge();
        last = PRESS_EDGE + n * l;
        win  = (last + 6 > 24) ? last + 6 : 24;
        for (int i = 1; i <= win; i++) begin
            // Second press reaches the top at edge 13 + LAT, inside the burst.
            step_btn = (i <= 6) || (repress && i >= 13 && i <= 18);
            next_edge();
            d        = i - PRESS_EDGE;
            exp_tick = (d > 0) && (d % n == 0) && (d / n <= l);
            exp_busy = (i >= PRESS_EDGE) && (i < last);
            if (exp_tick) model_ticks++;
            checks += 3;
            if (bus.tick_o !== exp_tick) begin errors++; $display("FAIL burst div=%0d len=%0d edge=%0d tick_o: got %b want %b", div, len, i, bus.tick_o, exp_tick); end
            if (bus.busy_o !== exp_busy) begin errors++; $display("FAIL burst div=%0d len=%0d edge=%0d busy_o: got %b want %b", div, len, i, bus.busy_o, exp_busy); end
            if (bus.tick_count_o !== 16'(model_ticks)) begin errors++; $display("FAIL burst div=%0d len=%0d edge=%0d tick_count_o: got %0d want %0d", div, len, i, bus.tick_count_o, 16'(model_ticks)); end
        end
    endtask

    task automatic test_abort();
        bit exp_tick;
        bit exp_busy;
        bus.mode_i      = BURST;
        bus.div_i       = 3;
        bus.burst_len_i = 5;
        repeat (3) next_edge();
        // Switch to HALT after the first tick of a 5-tick burst.
        for (int i = 1; i <= 30; i++) begin
            step_btn   = (i <= 6);
            bus.mode_i = (i >= 13) ? HALT : BURST;
            next_edge();
            exp_tick = (i == PRESS_EDGE + 3);
            exp_busy = (i >= PRESS_EDGE) && (i <= 12);
            if (exp_tick) model_ticks++;
            checks += 2;
            if (bus.tick_o !== exp_tick) begin errors++; $display("FAIL abort edge=%0d tick_o: got %b want %b", i, bus.tick_o, exp_tick); end
            if (bus.busy_o !== exp_busy) begin errors++; $display("FAIL abort edge=%0d busy_o: got %b want %b", i, bus.busy_o, exp_busy); end
        end
        // Reset in the middle of a burst.
        bus.mode_i = BURST;
        repeat (3) next_edge();
        for (int i = 1; i <= PRESS_EDGE + 2; i++) begin
            step_btn = (i <= 6);
            next_edge();
        end
        checks += 1;
        if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL reset_mid_burst pre busy_o: got %b want 1", bus.busy_o); end
        reset = 1'b1;
        next_edge();
        model_ticks = 0;
        checks += 4;
        if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL reset_mid_burst tick_o: got %b want 0", bus.tick_o); end
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_mid_burst busy_o: got %b want 0", bus.busy_o); end
        if (bus.tick_count_o !== 16'h0000) begin errors++; $display("FAIL reset_mid_burst tick_count_o: got %h want 0000", bus.tick_count_o); end
        if (bus.led_o !== 1'b0) begin errors++; $display("FAIL reset_mid_burst led_o: got %b want 0", bus.led_o); end
        reset      = 1'b0;
        bus.mode_i = HALT;
        next_edge();
    endtask

    task automatic test_wrap_and_reset();
        reset      = 1'b1;
        bus.mode_i = HALT;
        next_edge();
        reset       = 1'b0;
        model_ticks = 0;
        bus.div_i   = 0;
        bus.mode_i  = RUN;
        for (int k = 0; k <= 65536 + 3; k++) begin
            next_edge();
            if (k >= 1) model_ticks++;
            if (k == 65535 || k == 65536) begin
                checks += 3;
                if (bus.tick_o !== 1'b1) begin errors++; $display("FAIL wrap edge=%0d tick_o: got %b want 1", k, bus.tick_o); end
                if (bus.tick_count_o !== 16'(model_ticks)) begin errors++; $display("FAIL wrap edge=%0d tick_count_o: got %h want %h", k, bus.tick_count_o, 16'(model_ticks)); end
                if (bus.led_o !== model_ticks[0]) begin errors++; $display("FAIL wrap edge=%0d led_o: got %b want %b", k, bus.led_o, model_ticks[0]); end
            end
        end
        // Reset while RUN is ticking every cycle.
        reset = 1'b1;
        next_edge();
        model_ticks = 0;
        checks += 4;
        if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL reset_in_run tick_o: got %b want 0", bus.tick_o); end
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_in_run busy_o: got %b want 0", bus.busy_o); end
        if (bus.tick_count_o !== 16'h0000) begin errors++; $display("FAIL reset_in_run tick_count_o: got %h want 0000", bus.tick_count_o); end
        if (bus.led_o !== 1'b0) begin errors++; $display("FAIL reset_in_run led_o: got %b want 0", bus.led_o); end
        reset      = 1'b0;
        bus.mode_i = HALT;
        next_edge();
    endtask

    initial begin
        test_reset();
        test_run(4, 3);
        test_run(0, 4);
        for (int t = 0; t < 4; t++) begin
            test_run($urandom_range(0, 7), 3);
        end
        test_div_change();
        test_step();
        test_burst(2, 3, 1'b0);
        test_burst(4, 4, 1'b1);
        test_burst(2, 0, 1'b0);
        for (int t = 0; t < 2; t++) begin
            test_burst($urandom_range(0, 4), $urandom_range(0, 6), 1'b0);
        end
        test_abort();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Parametrised successor to the top-level free-running clock divider: instead of producing a derived clock, it emits a single-cycle clock-enable pulse (`tick_o`) on the one board clock, which gates every pipeline stage. It adds runtime-selectable HALT / RUN / STEP / BURST modes for bring-up and single-step debugging of the CPU on the FPGA. It also adds a runtime divisor, a debounced step button, a tick counter and a heartbeat LED. It sits at the top level between the board pins and the decode/pipeline/controller instances.

## Interface
- `CNT_W`, 32: width of divisor and divide counter.
- `DEFAULT_DIV`, 1: documentation only; the top level ties `div_i` to this value when no runtime control exists.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to accept a button level (≥1).
- `BURST_W`, 8: width of burst length.
- One clock; reset is synchronous and active-high.
- `clk` input 1: board clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `mode_i` input 2: 00 HALT, 01 RUN, 10 STEP, 11 BURST; quasi-static, sampled every cycle.
- `div_i` input CNT_W: tick period in cycles; 0 is treated as 1.
- `step_btn_i` input 1: raw asynchronous push-button, active-high.
- `burst_len_i` input BURST_W: ticks per burst; 0 is treated as 1; sampled at burst start.
- `tick_o` output 1: one-cycle clock-enable pulse, registered.
- `busy_o` output 1: burst in progress.
- `tick_count_o` output 16: total ticks since reset, wraps.
- `led_o` output 1: toggles on every tick.

## Operation
- Reset state: FSM = HALT, divide counter = 0, remaining = 0, debounced level = 0, synchroniser flops = 0. Output reset values: `tick_o` = 0, `busy_o` = 0, `tick_count_o` = 0, `led_o` = 0.
- Effective divisor: `div_eff = (div_i == 0) ? 1 : div_i`.
- Divide counter rule: at the terminal edge the counter clears and `tick_o` is set. The terminal condition uses a greater-or-equal compare (`cnt >= div_eff-1`), so lowering `div_i` mid-count ends the current period at the next edge instead of waiting for wrap.
- FSM states are HALT, RUN, STEP and BURST. The next state follows `mode_i` every cycle.
- Every state change clears the divide counter. Leaving BURST also clears `busy_o` and remaining, which aborts the burst.
- HALT: no ticks.
- RUN: ticks every `div_eff` cycles.
- STEP: each press event produces exactly one tick. `div_i` is ignored.
- BURST, press with `busy_o` = 0:
  - remaining ← `burst_len_eff`, `busy_o` ← 1, counter ← 0.
  - Ticks then follow the RUN spacing.
  - On the edge that emits the last tick, remaining reaches 0 and `busy_o` falls.
- BURST, press with `busy_o` = 1: the press is ignored.
- Press event: a rising edge of the debounced button level. The debounced level changes only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any glitch restarts the stability count.
- `tick_count_o` increments by 1 per tick and wraps 0xFFFF → 0x0000.
- `led_o` inverts per tick.

## Timing
- Define edge 0 as the first edge sampling `mode_i` = RUN with FSM ≠ RUN.
- RUN: `tick_o` is high in the cycle following edges N, 2N, 3N, … (N = `div_eff`). With N = 1, `tick_o` is high continuously from edge 1.
- Button latency: the raw rise must be held stable. Sync takes 2 edges, debounce `DEBOUNCE_CYCLES` edges, and the press is detected 1 edge later. In STEP, `tick_o` is set on the following edge. Total: 2 + `DEBOUNCE_CYCLES` + 1 edges from the first sampled-high edge.
- BURST: the first tick comes N edges after the press-detect edge. Consecutive ticks are N apart. `busy_o` goes low on the same edge `tick_o` rises for the last tick.
- A mode change takes effect on the sampling edge. A tick already registered still completes its single cycle.
- Reset asserted at an edge overrides everything, including mid-burst and mid-debounce. All outputs read their reset values in the following cycle.

## Structure
- Package `clk_gen_pkg`:
  - `mode_t` enum: HALT=2'b00, RUN=2'b01, STEP=2'b10, BURST=2'b11.
  - Constant `TICK_CNT_W` = 16.
- Sub-module `step_debouncer`, parameter `DEBOUNCE_CYCLES`: contains the 2-flop synchroniser, stability counter, debounced level and rising-edge pulse output `press_o`.
- The top block holds the FSM, divide counter, burst counter and output registers.

## Test plan
- Reset then RUN, `div_i` = 4: `tick_o` pulses at edges 4, 8, 12. `led_o` reads 1, 0, 1. `tick_count_o` reads 1, 2, 3.
- RUN, `div_i` = 0: behaves as 1, with `tick_o` held high from edge 1. Change `div_i` from 10 to 2 at counter = 5: a tick follows on the next edge, then the period is 2.
- STEP, `DEBOUNCE_CYCLES` = 4:
  - A 3-cycle glitch produces no tick.
  - A clean press held 20 cycles produces exactly one tick, 7 edges after the first sampled-high edge.
  - Release then press again produces a second tick.
- BURST, `burst_len_i` = 3, `div_i` = 2:
  - A press yields ticks at edges +2, +4, +6. `busy_o` is high from the press edge until the edge of the third tick.
  - A second press mid-burst is ignored.
  - `burst_len_i` = 0 yields one tick.
- Abort and reset: switch to HALT mid-burst, giving no further ticks and `busy_o` = 0 next cycle. Assert `reset` during RUN with `tick_count_o` = 0xFFFF: all outputs read 0. Preload 0xFFFF and tick once without reset: `tick_count_o` wraps to 0.
